lfsr: RTL and testbench
=======================

Name: lfsr

Overview:
- Pseudo-random number source built on a Fibonacci LFSR; the puzzle stage logic uses it to draw random 4-bit button codes.
- On request, the block advances the register OUT_WIDTH steps, then presents a fresh OUT_WIDTH-bit value with a one-cycle valid pulse.
- Supports seed reload and exposes the raw register state for debug and verification.

Parameters:
- WIDTH, 16, LFSR register width in bits.
- OUT_WIDTH, 4, bits per random draw; also the number of shifts per draw. Must satisfy 1 <= OUT_WIDTH <= WIDTH.
- TAPS, 16'hB400, feedback mask (x^16+x^14+x^13+x^11+1, maximal length).
- SEED, 16'hACE1, reset seed, and the replacement value for a zero seed. Must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  load seed into register.
- seed  in  WIDTH  seed value, sampled when load=1.
- req  in  1  request one random draw.
- busy  out  1  draw in progress.
- valid  out  1  one-cycle pulse: rand_out holds a new value.
- rand_out  out  OUT_WIDTH  last drawn value; holds until the next draw.
- state  out  WIDTH  current LFSR register.

Behaviour:
- Reset is synchronous, active-high, on clk rising edge. Reset values: state=SEED, busy=0, valid=0, rand_out=0, internal step counter=0.
- Shift step: fb = XOR-reduction of (state & TAPS); state_next = {state[WIDTH-2:0], fb}.
- Edge priority: rst > load > draw activity.
- Load, any cycle, including mid-draw:
  - state <= seed, or SEED if seed==0; the all-zero lockup state is unreachable.
  - busy <= 0, valid <= 0; an in-progress draw is aborted; rand_out unchanged.
  - A req in the same cycle is dropped.
- Draw acceptance: req=1 while busy=0 and load=0.
  - The accepting edge performs shift 1.
  - busy <= 1 if OUT_WIDTH>1; counter <= OUT_WIDTH-1.
- While busy, each edge performs one shift and decrements the counter.
- Completion, at the edge performing shift OUT_WIDTH:
  - busy <= 0, valid <= 1 for exactly one cycle.
  - rand_out <= post-shift state[OUT_WIDTH-1:0], which equals the OUT_WIDTH newly shifted-in feedback bits.
- Latency: req accepted at edge E0 → valid high in the cycle after edge E0+OUT_WIDTH-1 (default: 4 edges including E0).
- OUT_WIDTH=1: busy never asserts; valid pulses after the accepting edge.
- req while busy=1 is ignored; there is no queueing.
- req high in the cycle where valid=1 (busy already 0) is accepted, giving back-to-back draws every OUT_WIDTH cycles.
- With no draw and no load, state holds; there is no free-running mode.
- valid is 0 in every cycle except the completion pulse.
- Period with default TAPS: 65535 states. 65535 is coprime with 4, so 65535 consecutive draws return state to its start value.

Test Plan:
- Reset → state=0xACE1, busy=0, valid=0, rand_out=0; hold req=0 for 10 cycles → state stays 0xACE1.
- After reset, pulse req one cycle → state after each edge: 0x59C3, 0xB387, 0x670F, 0xCE1E. busy high for 3 cycles; valid pulses once; rand_out=0xE.
- load=1, seed=0x0000 → state=0xACE1. load=1, seed=0x1234 → state=0x1234.
- Start a draw, assert load with seed=0xACE1 on the second busy cycle → busy=0, valid never pulses, state=0xACE1, rand_out keeps its prior value.
- Pulse req again while busy → ignored: exactly one valid pulse, state advances exactly 4 steps total.
- Hold req continuously from reset for 65535 draws → valid every 4 cycles, state never 0, final state=0xACE1.

Source files
------------

// File: rtl/lfsr.sv
// Fibonacci LFSR random source: on req, shifts OUT_WIDTH times and
// presents the OUT_WIDTH new feedback bits with a one-cycle valid pulse.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   load     - load seed (zero seed replaced by SEED); aborts a draw
//   seed     - seed value sampled when load=1
//   req      - request one draw (accepted when idle and not loading)
//   busy     - draw in progress
//   valid    - one-cycle pulse, rand_out holds a new value
//   rand_out - last drawn value, held until the next draw completes
//   state    - raw LFSR register
module lfsr #(
    parameter int              WIDTH     = 16,
    parameter int              OUT_WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     seed,
    input  logic                 req,
    output logic                 busy,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] rand_out,
    output logic [WIDTH-1:0]     state
);

    localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } fsm_e;

    fsm_e                 r_fsm;
    fsm_e                 w_fsm_next;
    logic [WIDTH-1:0]     r_state;
    logic [WIDTH-1:0]     w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic                 r_valid;
    logic                 w_valid_next;
    logic [OUT_WIDTH-1:0] r_rand;
    logic [OUT_WIDTH-1:0] w_rand_next;

    logic                 w_fb;
    logic [WIDTH-1:0]     w_shift;
    logic [WIDTH-1:0]     w_seed;

    assign w_fb    = ^(r_state & TAPS);
    assign w_shift = {r_state[WIDTH-2:0], w_fb};
    // All-zero is the lockup state; never let a load reach it.
    assign w_seed  = (seed == '0) ? SEED : seed;

    always_comb begin
        w_fsm_next   = r_fsm;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_valid_next = 1'b0;
        w_rand_next  = r_rand;
        if (load) begin
            w_fsm_next   = S_IDLE;
            w_state_next = w_seed;
            w_cnt_next   = '0;
        end else begin
            unique case (r_fsm)
                S_IDLE: begin
                    if (req) begin
                        w_state_next = w_shift;
                        if (OUT_WIDTH == 1) begin
                            w_valid_next = 1'b1;
                            w_rand_next  = w_shift[OUT_WIDTH-1:0];
                        end else begin
                            w_fsm_next = S_BUSY;
                            w_cnt_next = CW'(OUT_WIDTH - 1);
                        end
                    end
                end
                S_BUSY: begin
                    w_state_next = w_shift;
                    w_cnt_next   = r_cnt - CW'(1);
                    // Counter at 1 means this edge does the final shift.
                    if (r_cnt == CW'(1)) begin
                        w_fsm_next   = S_IDLE;
                        w_valid_next = 1'b1;
                        w_rand_next  = w_shift[OUT_WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= SEED;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_rand  <= '0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            r_rand  <= w_rand_next;
        end
    end

    assign busy     = (r_fsm == S_BUSY);
    assign valid    = r_valid;
    assign rand_out = r_rand;
    assign state    = r_state;

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: directed vector table, abort and
// busy-req sequences, randomized transactions, and period wrap-around.
module tb_lfsr;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] seed;
    logic        req;
    logic        busy;
    logic        valid;
    logic [3:0]  rand_out;
    logic [15:0] state;

    int n_cmp = 0;
    int n_err = 0;

    lfsr dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .seed     (seed),
        .req      (req),
        .busy     (busy),
        .valid    (valid),
        .rand_out (rand_out),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        load;
        logic [15:0] seed;
        logic [15:0] st;
        logic        bsy;
        logic        vld;
        logic [3:0]  rnd;
    } vec_t;

    vec_t tbl [0:8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: x^16+x^14+x^13+x^11+1 -> tap bit positions 15,13,12,10.
    function automatic logic [15:0] m_step(input logic [15:0] s);
        int  taps [4] = '{15, 13, 12, 10};
        logic p = 1'b0;
        for (int i = 0; i < 4; i++) p = p ^ s[taps[i]];
        return {s[14:0], p};
    endfunction

    function automatic logic [15:0] m_draw(input logic [15:0] s);
        logic [15:0] t = s;
        for (int i = 0; i < 4; i++) t = m_step(t);
        return t;
    endfunction

    logic [15:0] m_st;
    logic [3:0]  m_rnd;
    logic [15:0] s;
    int          nv;
    int          lat;
    int          k;
    int          op;
    int          pat_err;
    int          zero_err;
    logic [15:0] pre;

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        seed = '0;
        req  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'hACE1);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_rand", 32'(rand_out), 0);

        nv = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid) nv++;
        end
        check("idle_state", 32'(state), 32'hACE1);
        check("idle_valid", 32'(nv), 0);

        tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'h59C3, 1'b1, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'hB387, 1'b1, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'h670F, 1'b1, 1'b0, 4'h0};
        tbl[3] = '{1'b0, 1'b0, 16'h0000, 16'hCE1E, 1'b0, 1'b1, 4'hE};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'hCE1E, 1'b0, 1'b0, 4'hE};
        tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'hACE1, 1'b0, 1'b0, 4'hE};
        tbl[6] = '{1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 4'hE};
        tbl[7] = '{1'b1, 1'b1, 16'h0000, 16'hACE1, 1'b0, 1'b0, 4'hE};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'hACE1, 1'b0, 1'b0, 4'hE};
        for (int i = 0; i < 9; i++) begin
            req  = tbl[i].req;
            load = tbl[i].load;
            seed = tbl[i].seed;
            tick();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].vld));
            check($sformatf("vec%0d_rand", i), 32'(rand_out), 32'(tbl[i].rnd));
        end
        req  = 1'b0;
        load = 1'b0;

        // Abort on second busy cycle.
        req = 1'b1;
        tick();
        req = 1'b0;
        check("abort_busy1", 32'(busy), 1);
        tick();
        check("abort_busy2", 32'(busy), 1);
        load = 1'b1;
        seed = 16'hACE1;
        tick();
        load = 1'b0;
        check("abort_state", 32'(state), 32'hACE1);
        check("abort_busy", 32'(busy), 0);
        nv = valid ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) nv++;
        end
        check("abort_nvalid", 32'(nv), 0);
        check("abort_rand", 32'(rand_out), 32'hE);

        // req held while busy is ignored.
        nv = 0;
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid) nv++;
        end
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid) nv++;
        end
        check("busyreq_nvalid", 32'(nv), 1);
        check("busyreq_state", 32'(state), 32'hCE1E);

        // Randomized transactions against the model.
        m_st  = 16'hCE1E;
        m_rnd = 4'hE;
        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    req = 1'b1;
                    tick();
                    lat = 1;
                    while (valid !== 1'b1 && lat < 12) begin
                        req = 1'($urandom_range(0, 1));
                        tick();
                        lat++;
                    end
                    req   = 1'b0;
                    m_st  = m_draw(m_st);
                    m_rnd = m_st[3:0];
                    check("rnd_lat", 32'(lat), 4);
                    check("rnd_rand", 32'(rand_out), 32'(m_rnd));
                    check("rnd_state", 32'(state), 32'(m_st));
                end
                1: begin
                    s = 16'($urandom);
                    if ($urandom_range(0, 3) == 0) s = '0;
                    load = 1'b1;
                    seed = s;
                    req  = 1'($urandom_range(0, 1));
                    tick();
                    load = 1'b0;
                    req  = 1'b0;
                    m_st = (s == 0) ? 16'hACE1 : s;
                    check("rnd_load", 32'(state), 32'(m_st));
                    check("rnd_load_busy", 32'(busy), 0);
                end
                2: begin
                    k = $urandom_range(1, 3);
                    req = 1'b1;
                    tick();
                    req = 1'b0;
                    for (int j = 1; j < k; j++) tick();
                    s = 16'($urandom);
                    load = 1'b1;
                    seed = s;
                    tick();
                    load = 1'b0;
                    m_st = (s == 0) ? 16'hACE1 : s;
                    check("rnd_abort", 32'(state), 32'(m_st));
                    check("rnd_abort_bv", 32'({busy, valid}), 0);
                    check("rnd_abort_rand", 32'(rand_out), 32'(m_rnd));
                end
                default: begin
                    nv = 0;
                    k = $urandom_range(1, 5);
                    for (int j = 0; j < k; j++) begin
                        tick();
                        if (valid) nv++;
                    end
                    check("rnd_idle", 32'(state), 32'(m_st));
                    check("rnd_idle_v", 32'(nv), 0);
                end
            endcase
        end

        // Continuous req from reset: valid every 4 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_state", 32'(state), 32'hACE1);
        m_st = 16'hACE1;
        pat_err  = 0;
        zero_err = 0;
        req = 1'b1;
        for (int d = 0; d < 2000; d++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (valid !== (c == 4)) pat_err++;
                if (busy !== (c != 4)) pat_err++;
                if (state == 0) zero_err++;
            end
            m_st = m_draw(m_st);
            if (d % 100 == 0)
                check("cont_state", 32'(state), 32'(m_st));
        end
        check("cont_pattern", 32'(pat_err), 0);
        check("cont_nonzero", 32'(zero_err), 0);

        // Jump near the end of the period, then finish the cycle.
        pre = 16'hACE1;
        for (int i = 0; i < (65535 - 200) * 4; i++) pre = m_step(pre);
        req  = 1'b0;
        load = 1'b1;
        seed = pre;
        tick();
        load = 1'b0;
        check("wrap_load", 32'(state), 32'(pre));
        req = 1'b1;
        pat_err  = 0;
        zero_err = 0;
        for (int d = 0; d < 200; d++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (valid !== (c == 4)) pat_err++;
                if (state == 0) zero_err++;
            end
        end
        req = 1'b0;
        check("wrap_pattern", 32'(pat_err), 0);
        check("wrap_nonzero", 32'(zero_err), 0);
        check("wrap_final", 32'(state), 32'hACE1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
